ex_mem_pipe: RTL and testbench

EX/MEM pipeline stage that sits directly downstream of the ALU compute block in the 5-stage pipeline. It registers the ALU result, the memory address, the store data and the control bits for the MEM stage. It also owns the architectural flag register (Z, V, N) and a sticky halt state machine. Its stall, flush and halt controls are what make this stage the hazard boundary between EX and MEM.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/flag_reg.sv | 36 +++
 rtl/ex_mem_pipe.sv | 102 ++++++++++
 tb/tb_ex_mem_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, flag indices and EX/MEM state encoding
package cpu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD    = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB    = 4'b0001;
  localparam logic [OP_W-1:0] OP_RED    = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR    = 4'b0011;
  localparam logic [OP_W-1:0] OP_SLL    = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRA    = 4'b0101;
  localparam logic [OP_W-1:0] OP_ROR    = 4'b0110;
  localparam logic [OP_W-1:0] OP_PADDSB = 4'b0111;
  localparam logic [OP_W-1:0] OP_LW     = 4'b1000;
  localparam logic [OP_W-1:0] OP_SW     = 4'b1001;
  localparam logic [OP_W-1:0] OP_LLB    = 4'b1010;
  localparam logic [OP_W-1:0] OP_LHB    = 4'b1011;
  localparam logic [OP_W-1:0] OP_B      = 4'b1100;
  localparam logic [OP_W-1:0] OP_BR     = 4'b1101;
  localparam logic [OP_W-1:0] OP_PCS    = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT    = 4'b1111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Which flag bits an opcode is allowed to rewrite.
  function automatic logic [2:0] flag_mask(input logic [OP_W-1:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flag_reg.sv
// rtl/flag_reg.sv - architectural {Z,V,N} register with per-opcode bit mask
module flag_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              ovf,
  input  logic              neg,
  output logic [2:0]        flags
);

  logic [2:0] mask;
  logic [2:0] next_val;

  always_comb begin
    mask             = flag_mask(opcode);
    next_val         = 3'b000;
    next_val[FLAG_Z] = ~|alu_out;
    next_val[FLAG_V] = ovf;
    next_val[FLAG_N] = neg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 3'b000;
    end else if (en) begin
      flags <= (flags & ~mask) | (next_val & mask);
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM pipeline register with flags and sticky halt
module ex_mem_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               ex_valid,
  input  logic [OP_W-1:0]    ex_opcode,
  input  logic [DATA_W-1:0]  ex_alu_out,
  input  logic [DATA_W-1:0]  ex_mem_addr,
  input  logic [DATA_W-1:0]  ex_store_data,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_reg_write,
  input  logic               ex_ovf,
  input  logic               ex_neg,
  output logic               mem_valid,
  output logic [OP_W-1:0]    mem_opcode,
  output logic [DATA_W-1:0]  mem_alu_out,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_store_data,
  output logic [RADDR_W-1:0] mem_rd,
  output logic               mem_reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic [2:0]         flags,
  output logic               halted
);

  state_t state;
  state_t state_nxt;
  logic   take;
  logic   flag_en;

  // An instruction is accepted only in RUN, with MEM ready and no flush.
  always_comb begin
    take      = ex_valid & ~flush & ~stall & (state == ST_RUN);
    flag_en   = take;
    state_nxt = state;
    if (state == ST_RUN && take && ex_opcode == OP_HLT) begin
      state_nxt = ST_HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  assign halted = (state == ST_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_opcode     <= '0;
      mem_alu_out    <= '0;
      mem_addr       <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
    end else if (state == ST_HALTED) begin
      // HLT already sat in MEM for its one cycle; drain to bubbles.
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
    end else if (!stall) begin
      mem_opcode     <= ex_opcode;
      mem_alu_out    <= ex_alu_out;
      mem_addr       <= ex_mem_addr;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
      mem_valid      <= take;
      mem_reg_write  <= take & ex_reg_write;
      mem_read       <= take & (ex_opcode == OP_LW);
      mem_write      <= take & (ex_opcode == OP_SW);
    end
  end

  flag_reg #(
    .DATA_W (DATA_W)
  ) u_flag_reg (
    .clk     (clk),
    .rst     (rst),
    .en      (flag_en),
    .opcode  (ex_opcode),
    .alu_out (ex_alu_out),
    .ovf     (ex_ovf),
    .neg     (ex_neg),
    .flags   (flags)
  );

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - self-checking bench for ex_mem_pipe
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_opcode = '0;
  logic [15:0] ex_alu_out = '0;
  logic [15:0] ex_mem_addr = '0;
  logic [15:0] ex_store_data = '0;
  logic [3:0]  ex_rd = '0;
  logic        ex_reg_write = 1'b0;
  logic        ex_ovf = 1'b0;
  logic        ex_neg = 1'b0;

  logic        mem_valid;
  logic [3:0]  mem_opcode;
  logic [15:0] mem_alu_out;
  logic [15:0] mem_addr;
  logic [15:0] mem_store_data;
  logic [3:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  flags;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_pipe #(.DATA_W(16), .RADDR_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out),
    .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_ovf(ex_ovf), .ex_neg(ex_neg),
    .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_alu_out(mem_alu_out),
    .mem_addr(mem_addr), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .flags(flags), .halted(halted)
  );

  // Expected architectural view of the MEM slot.
  logic        e_valid = 0, e_rw = 0, e_rd_en = 0, e_wr_en = 0, e_halt = 0;
  logic        e_known = 1;
  logic [3:0]  e_op = 0, e_rd = 0;
  logic [15:0] e_alu = 0, e_addr = 0, e_sd = 0;
  logic [2:0]  e_flags = 0;

  always @(posedge clk) begin
    if (rst) begin
      e_valid = 0; e_rw = 0; e_rd_en = 0; e_wr_en = 0; e_halt = 0;
      e_op = 0; e_rd = 0; e_alu = 0; e_addr = 0; e_sd = 0;
      e_flags = 0; e_known = 1;
    end else if (e_halt) begin
      e_valid = 0; e_rw = 0; e_rd_en = 0; e_wr_en = 0; e_known = 0;
    end else if (!stall) begin
      e_valid = ex_valid && !flush;
      e_known = e_valid;
      e_op = ex_opcode; e_alu = ex_alu_out; e_addr = ex_mem_addr;
      e_sd = ex_store_data; e_rd = ex_rd;
      e_rw    = e_valid && ex_reg_write;
      e_rd_en = e_valid && ex_opcode == 4'd8;
      e_wr_en = e_valid && ex_opcode == 4'd9;
      if (e_valid) begin
        if (ex_opcode <= 4'd1)
          e_flags = {ex_alu_out == 16'd0, ex_ovf, ex_neg};
        else if (ex_opcode >= 4'd3 && ex_opcode <= 4'd6)
          e_flags[2] = (ex_alu_out == 16'd0);
        if (ex_opcode == 4'd15) e_halt = 1;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("mem_valid", 32'(mem_valid), 32'(e_valid));
    cmp("mem_reg_write", 32'(mem_reg_write), 32'(e_rw));
    cmp("mem_read", 32'(mem_read), 32'(e_rd_en));
    cmp("mem_write", 32'(mem_write), 32'(e_wr_en));
    cmp("flags", 32'(flags), 32'(e_flags));
    cmp("halted", 32'(halted), 32'(e_halt));
    if (e_known) begin
      cmp("mem_opcode", 32'(mem_opcode), 32'(e_op));
      cmp("mem_alu_out", 32'(mem_alu_out), 32'(e_alu));
      cmp("mem_addr", 32'(mem_addr), 32'(e_addr));
      cmp("mem_store_data", 32'(mem_store_data), 32'(e_sd));
      cmp("mem_rd", 32'(mem_rd), 32'(e_rd));
    end
  end

  // Drive one cycle of inputs, then return just after the following negedge.
  task automatic step(input logic s, input logic f, input logic v, input logic [3:0] op,
                      input logic [15:0] alu, input logic [15:0] addr, input logic [15:0] sd,
                      input logic [3:0] rd, input logic rw, input logic ovf, input logic neg);
    stall = s; flush = f; ex_valid = v; ex_opcode = op; ex_alu_out = alu;
    ex_mem_addr = addr; ex_store_data = sd; ex_rd = rd; ex_reg_write = rw;
    ex_ovf = ovf; ex_neg = neg;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("lit_reset_flags", 32'(flags), 32'h0);
    cmp("lit_reset_halted", 32'(halted), 32'h0);
    rst = 0;

    step(0, 0, 1, 4'h0, 16'h0000, 16'h0010, 16'h0, 4'd1, 1, 1, 0);
    cmp("lit_add_flags", 32'(flags), 32'h6);
    cmp("lit_add_valid", 32'(mem_valid), 32'h1);
    cmp("lit_add_rw", 32'(mem_reg_write), 32'h1);
    cmp("lit_model_add", 32'(e_flags), 32'h6);

    step(0, 0, 1, 4'h1, 16'h0005, 16'h0, 16'h0, 4'd2, 1, 1, 1);
    cmp("lit_sub_flags", 32'(flags), 32'h3);
    step(0, 0, 1, 4'h3, 16'h0001, 16'h0, 16'h0, 4'd2, 1, 0, 0);
    cmp("lit_xor1_flags", 32'(flags), 32'h3);
    step(0, 0, 1, 4'h3, 16'h0000, 16'h0, 16'h0, 4'd2, 1, 0, 0);
    cmp("lit_xor0_flags", 32'(flags), 32'h7);

    step(0, 0, 1, 4'h8, 16'h0, 16'h1234, 16'h0, 4'd3, 1, 0, 0);
    step(1, 0, 1, 4'h0, 16'h0, 16'h5555, 16'h0, 4'd4, 1, 1, 1);
    cmp("lit_stall1_addr", 32'(mem_addr), 32'h1234);
    cmp("lit_stall1_read", 32'(mem_read), 32'h1);
    step(1, 1, 1, 4'h1, 16'h9, 16'hAAAA, 16'h0, 4'd5, 1, 0, 1);
    cmp("lit_stall2_addr", 32'(mem_addr), 32'h1234);
    cmp("lit_stall2_flags", 32'(flags), 32'h7);

    step(0, 1, 1, 4'h0, 16'h0000, 16'h0, 16'h0, 4'd6, 1, 0, 0);
    cmp("lit_flush_valid", 32'(mem_valid), 32'h0);
    cmp("lit_flush_flags", 32'(flags), 32'h7);
    step(1, 1, 1, 4'h0, 16'h0000, 16'h0, 16'h0, 4'd6, 1, 0, 0);
    cmp("lit_flushstall_rw", 32'(mem_reg_write), 32'h0);

    step(0, 1, 1, 4'hF, 16'h0, 16'h0, 16'h0, 4'd0, 0, 0, 0);
    step(1, 0, 1, 4'hF, 16'h0, 16'h0, 16'h0, 4'd0, 0, 0, 0);
    cmp("lit_hlt_not_taken", 32'(halted), 32'h0);

    step(0, 0, 1, 4'h9, 16'h0002, 16'h0040, 16'hBEEF, 4'd0, 0, 1, 1);
    cmp("lit_sw_write", 32'(mem_write), 32'h1);
    cmp("lit_sw_data", 32'(mem_store_data), 32'hBEEF);
    step(0, 0, 1, 4'hA, 16'h0000, 16'h0, 16'h0, 4'd7, 1, 1, 1);
    cmp("lit_llb_write", 32'(mem_write), 32'h0);
    cmp("lit_llb_rw", 32'(mem_reg_write), 32'h1);
    cmp("lit_llb_flags", 32'(flags), 32'h7);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 5) != 0), op,
           ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom),
           16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    end

    step(0, 0, 1, 4'h1, 16'h0000, 16'h0, 16'h0, 4'd1, 1, 0, 1);
    step(0, 0, 1, 4'hF, 16'h0, 16'h0, 16'h0, 4'd0, 0, 0, 0);
    cmp("lit_hlt_op", 32'(mem_opcode), 32'hF);
    cmp("lit_hlt_valid", 32'(mem_valid), 32'h1);
    cmp("lit_hlt_halted", 32'(halted), 32'h1);
    step(0, 0, 1, 4'h0, 16'h0007, 16'h0, 16'h0, 4'd2, 1, 1, 0);
    cmp("lit_halt_bubble", 32'(mem_valid), 32'h0);
    cmp("lit_halt_flags", 32'(flags), 32'h5);
    step(1, 1, 1, 4'h8, 16'h0, 16'h0, 16'h0, 4'd2, 1, 1, 0);
    cmp("lit_halt_sticky", 32'(halted), 32'h1);
    rst = 1;
    step(1, 1, 1, 4'h0, 16'h0, 16'h0, 16'h0, 4'd2, 1, 1, 0);
    cmp("lit_rst_halted", 32'(halted), 32'h0);
    cmp("lit_rst_opcode", 32'(mem_opcode), 32'h0);
    cmp("lit_rst_flags", 32'(flags), 32'h0);
    rst = 0;
    step(0, 0, 1, 4'h0, 16'h0000, 16'h1, 16'h2, 4'd3, 1, 1, 1);
    cmp("lit_post_rst_flags", 32'(flags), 32'h7);
    step(0, 0, 0, 4'h0, 16'h0, 16'h0, 16'h0, 4'd0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
